ex_alu_rs: RTL and testbench

- Parametrised successor to the single-slot ALU execute stage.
- A DEPTH-entry ALU reservation station with tag-based operand wakeup from the common data bus (CDB).
- Issues the oldest ready entry to a single-cycle ALU/branch unit; result is held in a valid/ready output register feeding the CDB arbiter and fetch redirect.
- Adds conditional branches, back-pressure, flush and same-cycle dispatch bypass; the single-slot stage had none of these.

---
 rtl/ex_alu_rs_if.sv | 59 +++++
 rtl/ex_alu_rs.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_ex_alu_rs.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_alu_rs_if.sv
// Bundle of the dispatch, CDB and result channels of the ALU reservation station.
// The station itself connects through the slave modport. The upstream/downstream
// environment connects through the master modport.
interface ex_alu_rs_if #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter int RADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // dispatch channel
    logic               disp_valid;
    logic               disp_ready;
    logic [OP_W-1:0]    disp_op;
    logic [XLEN-1:0]    disp_pc;
    logic [TAG_W-1:0]   disp_tagx;
    logic [TAG_W-1:0]   disp_tagy;
    logic [XLEN-1:0]    disp_datax;
    logic [XLEN-1:0]    disp_datay;
    logic [XLEN-1:0]    disp_imm;
    logic [TAG_W-1:0]   disp_rtag;
    logic [RADDR_W-1:0] disp_target;

    // common data bus snoop
    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic [XLEN-1:0]    cdb_data;

    // result channel
    logic               res_valid;
    logic               res_ready;
    logic [TAG_W-1:0]   res_tag;
    logic               res_wen;
    logic [RADDR_W-1:0] res_target;
    logic [XLEN-1:0]    res_data;
    logic               res_jmp_en;
    logic [XLEN-1:0]    res_jmp_addr;

    // occupancy
    logic [CNT_W-1:0]   count;

    modport slave (
        input  disp_valid, disp_op, disp_pc, disp_tagx, disp_tagy,
               disp_datax, disp_datay, disp_imm, disp_rtag, disp_target,
               cdb_valid, cdb_tag, cdb_data, res_ready,
        output disp_ready, res_valid, res_tag, res_wen, res_target,
               res_data, res_jmp_en, res_jmp_addr, count
    );

    modport master (
        output disp_valid, disp_op, disp_pc, disp_tagx, disp_tagy,
               disp_datax, disp_datay, disp_imm, disp_rtag, disp_target,
               cdb_valid, cdb_tag, cdb_data, res_ready,
        input  disp_ready, res_valid, res_tag, res_wen, res_target,
               res_data, res_jmp_en, res_jmp_addr, count
    );
endinterface

// File: rtl/ex_alu_rs.sv
// ALU reservation station: DEPTH-entry compacting queue (entry 0 oldest) with
// CDB tag wakeup, same-cycle dispatch bypass, oldest-ready issue into a single
// cycle ALU/branch unit and a valid/ready result register.
module ex_alu_rs #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter int RADDR_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rdy,
    input  logic flush,
    ex_alu_rs_if.slave bus
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int IW   = $clog2(DEPTH);
    localparam int SH_W = $clog2(XLEN);

    // instruction-class codes; 0 and anything above BGEU are treated as unknown
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(9);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(12);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(16);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(17);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(18);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(20);

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [XLEN-1:0]    pc;
        logic [TAG_W-1:0]   tagx;
        logic [TAG_W-1:0]   tagy;
        logic [XLEN-1:0]    datax;
        logic [XLEN-1:0]    datay;
        logic [XLEN-1:0]    imm;
        logic [TAG_W-1:0]   rtag;
        logic [RADDR_W-1:0] target;
    } ent_t;

    ent_t             ent_r    [DEPTH];
    ent_t             woke_s   [DEPTH];
    ent_t             ent_nx_s [DEPTH];
    ent_t             in_s;
    ent_t             sel_e_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nx_s;
    logic [CW-1:0]    wr_idx_s;
    logic [IW-1:0]    sel_s;
    logic             found_s;
    logic             issue_s;
    logic             acc_s;
    logic             cdb_hit_s;
    logic             disp_ready_s;

    logic             res_valid_r;
    logic [TAG_W-1:0] res_tag_r;
    logic             res_wen_r;
    logic [RADDR_W-1:0] res_target_r;
    logic [XLEN-1:0]  res_data_r;
    logic             res_jen_r;
    logic [XLEN-1:0]  res_jaddr_r;

    logic [XLEN-1:0]  opx_s;
    logic [XLEN-1:0]  opy_s;
    logic [SH_W-1:0]  sh_s;
    logic [XLEN-1:0]  link_s;
    logic [XLEN-1:0]  br_tgt_s;
    logic [XLEN-1:0]  jalr_sum_s;
    logic             taken_s;
    logic [XLEN-1:0]  alu_data_s;
    logic             alu_wen_s;
    logic             alu_jen_s;
    logic [XLEN-1:0]  alu_jaddr_s;

    // a zero broadcast tag never wakes anything: tag 0 already means ready
    assign cdb_hit_s    = bus.cdb_valid && (bus.cdb_tag != {TAG_W{1'b0}});
    // free-slot view is registered occupancy only; a same-cycle issue does not count
    assign disp_ready_s = (count_r < CW'(DEPTH)) && !flush;
    assign acc_s        = rdy && bus.disp_valid && disp_ready_s;
    assign issue_s      = found_s && (!res_valid_r || bus.res_ready);

    // CDB wakeup of the operands held in valid entries
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke_s[i] = ent_r[i];
            if (cdb_hit_s && (CW'(i) < count_r) && (ent_r[i].tagx == bus.cdb_tag)) begin
                woke_s[i].tagx  = {TAG_W{1'b0}};
                woke_s[i].datax = bus.cdb_data;
            end else begin
                woke_s[i].tagx  = ent_r[i].tagx;
            end
            if (cdb_hit_s && (CW'(i) < count_r) && (ent_r[i].tagy == bus.cdb_tag)) begin
                woke_s[i].tagy  = {TAG_W{1'b0}};
                woke_s[i].datay = bus.cdb_data;
            end else begin
                woke_s[i].tagy  = ent_r[i].tagy;
            end
        end
    end

    // incoming entry, with operands captured from a same-cycle broadcast
    always_comb begin
        in_s.op     = bus.disp_op;
        in_s.pc     = bus.disp_pc;
        in_s.tagx   = bus.disp_tagx;
        in_s.tagy   = bus.disp_tagy;
        in_s.datax  = bus.disp_datax;
        in_s.datay  = bus.disp_datay;
        in_s.imm    = bus.disp_imm;
        in_s.rtag   = bus.disp_rtag;
        in_s.target = bus.disp_target;
        if (cdb_hit_s && (bus.disp_tagx == bus.cdb_tag)) begin
            in_s.tagx  = {TAG_W{1'b0}};
            in_s.datax = bus.cdb_data;
        end else begin
            in_s.tagx  = bus.disp_tagx;
        end
        if (cdb_hit_s && (bus.disp_tagy == bus.cdb_tag)) begin
            in_s.tagy  = {TAG_W{1'b0}};
            in_s.datay = bus.cdb_data;
        end else begin
            in_s.tagy  = bus.disp_tagy;
        end
    end

    // pick the lowest-index (oldest) entry whose operands are both unlocked
    always_comb begin
        found_s = 1'b0;
        sel_s   = {IW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (!found_s && (CW'(i) < count_r) &&
                (ent_r[i].tagx == {TAG_W{1'b0}}) && (ent_r[i].tagy == {TAG_W{1'b0}})) begin
                found_s = 1'b1;
                sel_s   = IW'(i);
            end else begin
                found_s = found_s;
            end
        end
        sel_e_s = ent_r[sel_s];
    end

    // next queue image: shift above the issued slot, then append the dispatch
    always_comb begin
        wr_idx_s   = issue_s ? (count_r - CW'(1)) : count_r;
        count_nx_s = count_r + CW'(acc_s) - CW'(issue_s);
        for (int i = 0; i < DEPTH; i++) begin
            ent_nx_s[i] = woke_s[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (issue_s && (IW'(i) >= sel_s)) begin
                ent_nx_s[i] = woke_s[i + 1];
            end else begin
                ent_nx_s[i] = woke_s[i];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (acc_s && (CW'(i) == wr_idx_s)) begin
                ent_nx_s[i] = in_s;
            end else begin
                ent_nx_s[i] = ent_nx_s[i];
            end
        end
    end

    // operand views and shared adders of the issuing entry
    always_comb begin
        opx_s      = sel_e_s.datax;
        opy_s      = sel_e_s.datay;
        sh_s       = sel_e_s.datay[SH_W-1:0];
        link_s     = sel_e_s.pc + XLEN'(4);
        br_tgt_s   = sel_e_s.pc + sel_e_s.imm;
        jalr_sum_s = sel_e_s.datax + sel_e_s.datay;
    end

    // branch condition of the issuing entry
    always_comb begin
        case (sel_e_s.op)
            OP_BEQ:  taken_s = (opx_s == opy_s);
            OP_BNE:  taken_s = (opx_s != opy_s);
            OP_BLT:  taken_s = ($signed(opx_s) <  $signed(opy_s));
            OP_BGE:  taken_s = ($signed(opx_s) >= $signed(opy_s));
            OP_BLTU: taken_s = (opx_s <  opy_s);
            OP_BGEU: taken_s = (opx_s >= opy_s);
            default: taken_s = 1'b0;
        endcase
    end

    // single-cycle ALU / branch evaluation and writeback flags
    always_comb begin
        alu_data_s  = {XLEN{1'b0}};
        alu_wen_s   = 1'b0;
        alu_jen_s   = 1'b0;
        alu_jaddr_s = {XLEN{1'b0}};
        case (sel_e_s.op)
            OP_ADD:   begin alu_data_s = opx_s + opy_s;                     alu_wen_s = 1'b1; end
            OP_SUB:   begin alu_data_s = opx_s - opy_s;                     alu_wen_s = 1'b1; end
            OP_SLL:   begin alu_data_s = opx_s << sh_s;                     alu_wen_s = 1'b1; end
            OP_SLT:   begin alu_data_s = XLEN'($signed(opx_s) < $signed(opy_s)); alu_wen_s = 1'b1; end
            OP_SLTU:  begin alu_data_s = XLEN'(opx_s < opy_s);              alu_wen_s = 1'b1; end
            OP_XOR:   begin alu_data_s = opx_s ^ opy_s;                     alu_wen_s = 1'b1; end
            OP_SRL:   begin alu_data_s = opx_s >> sh_s;                     alu_wen_s = 1'b1; end
            OP_SRA:   begin alu_data_s = $unsigned($signed(opx_s) >>> sh_s); alu_wen_s = 1'b1; end
            OP_OR:    begin alu_data_s = opx_s | opy_s;                     alu_wen_s = 1'b1; end
            OP_AND:   begin alu_data_s = opx_s & opy_s;                     alu_wen_s = 1'b1; end
            OP_LUI:   begin alu_data_s = opx_s;                             alu_wen_s = 1'b1; end
            OP_AUIPC: begin alu_data_s = sel_e_s.pc + opx_s;                alu_wen_s = 1'b1; end
            // JAL redirect is handled at fetch; only the link value and address are reported
            OP_JAL: begin
                alu_data_s  = link_s;
                alu_wen_s   = 1'b1;
                alu_jaddr_s = sel_e_s.pc + opx_s;
            end
            OP_JALR: begin
                alu_data_s  = link_s;
                alu_wen_s   = 1'b1;
                alu_jen_s   = 1'b1;
                alu_jaddr_s = {jalr_sum_s[XLEN-1:1], 1'b0};
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                alu_jen_s   = taken_s;
                alu_jaddr_s = taken_s ? br_tgt_s : {XLEN{1'b0}};
            end
            default: begin
                alu_data_s  = {XLEN{1'b0}};
                alu_wen_s   = 1'b0;
                alu_jen_s   = 1'b0;
                alu_jaddr_s = {XLEN{1'b0}};
            end
        endcase
    end

    // station entries and occupancy; flush empties the queue and drops any dispatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_nx_s;
                for (int i = 0; i < DEPTH; i++) begin
                    ent_r[i] <= ent_nx_s[i];
                end
            end
        end
    end

    // result register: loads on issue, empties on handshake, fields otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r  <= 1'b0;
            res_tag_r    <= {TAG_W{1'b0}};
            res_wen_r    <= 1'b0;
            res_target_r <= {RADDR_W{1'b0}};
            res_data_r   <= {XLEN{1'b0}};
            res_jen_r    <= 1'b0;
            res_jaddr_r  <= {XLEN{1'b0}};
        end else if (rdy) begin
            if (flush) begin
                res_valid_r <= 1'b0;
            end else if (issue_s) begin
                res_valid_r  <= 1'b1;
                res_tag_r    <= sel_e_s.rtag;
                res_wen_r    <= alu_wen_s;
                res_target_r <= sel_e_s.target;
                res_data_r   <= alu_data_s;
                res_jen_r    <= alu_jen_s;
                res_jaddr_r  <= alu_jaddr_s;
            end else if (res_valid_r && bus.res_ready) begin
                res_valid_r <= 1'b0;
            end
        end
    end

    assign bus.disp_ready   = disp_ready_s;
    assign bus.count        = count_r;
    assign bus.res_valid    = res_valid_r;
    assign bus.res_tag      = res_tag_r;
    assign bus.res_wen      = res_wen_r;
    assign bus.res_target   = res_target_r;
    assign bus.res_data     = res_data_r;
    assign bus.res_jmp_en   = res_jen_r;
    assign bus.res_jmp_addr = res_jaddr_r;
endmodule

// File: tb/tb_ex_alu_rs.sv
// Directed bench for the ALU reservation station: reset, basic issue, wakeup
// ordering, dispatch bypass, fill/back-pressure, op table, flush/rdy/reset.
module tb_ex_alu_rs;
    localparam logic [5:0] OP_ADD = 6'd1,  OP_SUB = 6'd2,  OP_SLL = 6'd3,  OP_SLT = 6'd4;
    localparam logic [5:0] OP_SLTU = 6'd5, OP_XOR = 6'd6,  OP_SRL = 6'd7,  OP_SRA = 6'd8;
    localparam logic [5:0] OP_OR = 6'd9,   OP_AND = 6'd10, OP_LUI = 6'd11, OP_AUIPC = 6'd12;
    localparam logic [5:0] OP_JAL = 6'd13, OP_JALR = 6'd14, OP_BEQ = 6'd15, OP_BNE = 6'd16;
    localparam logic [5:0] OP_BLT = 6'd17, OP_BGE = 6'd18, OP_BLTU = 6'd19, OP_BGEU = 6'd20;

    logic clk;
    logic rst_n;
    logic rdy;
    logic flush;
    int   n_cmp;
    int   n_err;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] imm;
        logic [31:0] d;
        logic        wen;
        logic        jen;
        logic [31:0] ja;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    ex_alu_rs_if #(.XLEN(32), .DEPTH(4), .TAG_W(4), .OP_W(6), .RADDR_W(5)) bus ();

    ex_alu_rs #(.XLEN(32), .DEPTH(4), .TAG_W(4), .OP_W(6), .RADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [5:0] op, input logic [31:0] pc,
                              input logic [3:0] tx, input logic [3:0] ty,
                              input logic [31:0] dx, input logic [31:0] dy,
                              input logic [31:0] imm, input logic [3:0] rt,
                              input logic [4:0] tg);
        bus.disp_valid  = 1'b1;
        bus.disp_op     = op;
        bus.disp_pc     = pc;
        bus.disp_tagx   = tx;
        bus.disp_tagy   = ty;
        bus.disp_datax  = dx;
        bus.disp_datay  = dy;
        bus.disp_imm    = imm;
        bus.disp_rtag   = rt;
        bus.disp_target = tg;
    endtask

    task automatic idle_inputs;
        bus.disp_valid = 1'b0;
        bus.disp_op = 6'd0; bus.disp_pc = 32'd0; bus.disp_tagx = 4'd0; bus.disp_tagy = 4'd0;
        bus.disp_datax = 32'd0; bus.disp_datay = 32'd0; bus.disp_imm = 32'd0;
        bus.disp_rtag = 4'd0; bus.disp_target = 5'd0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = 4'd0; bus.cdb_data = 32'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; rdy = 1'b1; flush = 1'b0; bus.res_ready = 1'b1;
        idle_inputs();
        #2 rst_n = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
        n_cmp++; if (bus.res_wen !== 1'b0 || bus.res_jmp_en !== 1'b0) begin n_err++; $display("FAIL reset_flags: got wen=%b jen=%b want 0 0", bus.res_wen, bus.res_jmp_en); end
        n_cmp++; if (bus.res_tag !== 4'd0 || bus.res_target !== 5'd0) begin n_err++; $display("FAIL reset_tag: got tag=%0d tgt=%0d want 0 0", bus.res_tag, bus.res_target); end
        n_cmp++; if (bus.res_data !== 32'd0 || bus.res_jmp_addr !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", bus.res_data, bus.res_jmp_addr); end
        n_cmp++; if (bus.disp_ready !== 1'b1) begin n_err++; $display("FAIL reset_disp_ready: got %b want 1", bus.disp_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        bus.res_ready = 1'b1;
        drive_disp(OP_ADD, 32'h0, 4'd0, 4'd0, 32'd5, 32'd7, 32'd0, 4'd3, 5'd1);
        tick();
        n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL add_count_e0: got %0d want 1", bus.count); end
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL add_valid_e0: got %b want 0", bus.res_valid); end
        idle_inputs();
        tick();
        n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL add_valid_e1: got %b want 1", bus.res_valid); end
        n_cmp++; if (bus.res_data !== 32'd12) begin n_err++; $display("FAIL add_data: got %h want %h", bus.res_data, 32'd12); end
        n_cmp++; if (bus.res_tag !== 4'd3 || bus.res_wen !== 1'b1 || bus.res_target !== 5'd1) begin n_err++; $display("FAIL add_fields: got tag=%0d wen=%b tgt=%0d want 3 1 1", bus.res_tag, bus.res_wen, bus.res_target); end
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL add_count_e1: got %0d want 0", bus.count); end
        tick();
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL add_consumed: got %b want 0", bus.res_valid); end
    endtask

    task automatic test_wakeup;
        bus.res_ready = 1'b1;
        drive_disp(OP_SUB, 32'h0, 4'd2, 4'd0, 32'd0, 32'd3, 32'd0, 4'd4, 5'd2);
        tick();
        drive_disp(OP_ADD, 32'h0, 4'd0, 4'd0, 32'd1, 32'd1, 32'd0, 4'd5, 5'd3);
        tick();
        n_cmp++; if (bus.count !== 3'd2 || bus.res_valid !== 1'b0) begin n_err++; $display("FAIL wake_pending: got count=%0d valid=%b want 2 0", bus.count, bus.res_valid); end
        idle_inputs();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd2; bus.cdb_data = 32'd10;
        tick();
        n_cmp++; if (bus.res_tag !== 4'd5 || bus.res_data !== 32'd2) begin n_err++; $display("FAIL wake_add_first: got tag=%0d data=%h want 5 2", bus.res_tag, bus.res_data); end
        n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL wake_count: got %0d want 1", bus.count); end
        idle_inputs();
        tick();
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd4 || bus.res_data !== 32'd7) begin n_err++; $display("FAIL wake_sub: got v=%b tag=%0d data=%h want 1 4 7", bus.res_valid, bus.res_tag, bus.res_data); end
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL wake_empty: got %0d want 0", bus.count); end
        tick();
    endtask

    task automatic test_bypass;
        bus.res_ready = 1'b1;
        drive_disp(OP_OR, 32'h0, 4'd0, 4'd5, 32'd6, 32'h0000dead, 32'd0, 4'd6, 5'd4);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd5; bus.cdb_data = 32'd9;
        tick();
        n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL byp_count: got %0d want 1", bus.count); end
        idle_inputs();
        tick();
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd15 || bus.res_tag !== 4'd6) begin n_err++; $display("FAIL byp_result: got v=%b data=%h tag=%0d want 1 f 6", bus.res_valid, bus.res_data, bus.res_tag); end
        tick();
    endtask

    task automatic test_back_to_back;
        bus.res_ready = 1'b0;
        drive_disp(OP_ADD,  32'h0, 4'd0, 4'd0, 32'd1, 32'd2, 32'd0, 4'd1, 5'd1); tick();
        drive_disp(OP_SLL,  32'h0, 4'd0, 4'd0, 32'd3, 32'h21, 32'd0, 4'd2, 5'd2); tick();
        drive_disp(OP_SRA,  32'h0, 4'd7, 4'd0, 32'd0, 32'd4, 32'd0, 4'd3, 5'd3); tick();
        drive_disp(OP_SLTU, 32'h0, 4'd0, 4'd0, 32'd1, 32'hffffffff, 32'd0, 4'd4, 5'd4); tick();
        drive_disp(OP_SLT,  32'h0, 4'd0, 4'd0, 32'hffffffff, 32'd1, 32'd0, 4'd5, 5'd5); tick();
        n_cmp++; if (bus.count !== 3'd4 || bus.disp_ready !== 1'b0) begin n_err++; $display("FAIL full_state: got count=%0d drdy=%b want 4 0", bus.count, bus.disp_ready); end
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd1 || bus.res_data !== 32'd3) begin n_err++; $display("FAIL full_first: got v=%b tag=%0d data=%h want 1 1 3", bus.res_valid, bus.res_tag, bus.res_data); end
        drive_disp(OP_ADD, 32'h0, 4'd0, 4'd0, 32'd9, 32'd9, 32'd0, 4'd6, 5'd6); tick();
        n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL full_reject: got count=%0d want 4", bus.count); end
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd1 || bus.res_data !== 32'd3) begin n_err++; $display("FAIL full_hold: got v=%b tag=%0d data=%h want 1 1 3", bus.res_valid, bus.res_tag, bus.res_data); end
        idle_inputs();
        bus.res_ready = 1'b1;
        tick();
        n_cmp++; if (bus.res_tag !== 4'd2 || bus.res_data !== 32'd6 || bus.count !== 3'd3) begin n_err++; $display("FAIL drain_b: got tag=%0d data=%h count=%0d want 2 6 3", bus.res_tag, bus.res_data, bus.count); end
        tick();
        n_cmp++; if (bus.res_tag !== 4'd4 || bus.res_data !== 32'd1 || bus.count !== 3'd2) begin n_err++; $display("FAIL drain_d: got tag=%0d data=%h count=%0d want 4 1 2", bus.res_tag, bus.res_data, bus.count); end
        tick();
        n_cmp++; if (bus.res_tag !== 4'd5 || bus.res_data !== 32'd1 || bus.count !== 3'd1) begin n_err++; $display("FAIL drain_e: got tag=%0d data=%h count=%0d want 5 1 1", bus.res_tag, bus.res_data, bus.count); end
        tick();
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.count !== 3'd1) begin n_err++; $display("FAIL drain_stall: got v=%b count=%0d want 0 1", bus.res_valid, bus.count); end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd7; bus.cdb_data = 32'h80000000;
        tick();
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL drain_wake_cycle: got v=%b want 0", bus.res_valid); end
        idle_inputs();
        tick();
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd3 || bus.res_data !== 32'hf8000000 || bus.count !== 3'd0) begin n_err++; $display("FAIL drain_c: got v=%b tag=%0d data=%h count=%0d want 1 3 f8000000 0", bus.res_valid, bus.res_tag, bus.res_data, bus.count); end
        tick();
    endtask

    task automatic test_alu_ops;
        vt[0]  = '{OP_SUB,   32'h0,   32'h0,        32'h1,        32'h0,  32'hffffffff, 1'b1, 1'b0, 32'h0};
        vt[1]  = '{OP_ADD,   32'h0,   32'hffffffff, 32'h2,        32'h0,  32'h1,        1'b1, 1'b0, 32'h0};
        vt[2]  = '{OP_AND,   32'h0,   32'hf0f0,     32'h0ff0,     32'h0,  32'h00f0,     1'b1, 1'b0, 32'h0};
        vt[3]  = '{OP_XOR,   32'h0,   32'hff,       32'h0f,       32'h0,  32'hf0,       1'b1, 1'b0, 32'h0};
        vt[4]  = '{OP_SRL,   32'h0,   32'h80000000, 32'h3f,       32'h0,  32'h1,        1'b1, 1'b0, 32'h0};
        vt[5]  = '{OP_SRA,   32'h0,   32'h80000000, 32'h4,        32'h0,  32'hf8000000, 1'b1, 1'b0, 32'h0};
        vt[6]  = '{OP_SLT,   32'h0,   32'hffffffff, 32'h1,        32'h0,  32'h1,        1'b1, 1'b0, 32'h0};
        vt[7]  = '{OP_SLTU,  32'h0,   32'hffffffff, 32'h1,        32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
        vt[8]  = '{OP_LUI,   32'h0,   32'h12345000, 32'h0,        32'h0,  32'h12345000, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{OP_AUIPC, 32'h1000, 32'h2000,    32'h0,        32'h0,  32'h3000,     1'b1, 1'b0, 32'h0};
        vt[10] = '{OP_JAL,   32'h200, 32'h10,       32'h0,        32'h0,  32'h204,      1'b1, 1'b0, 32'h210};
        vt[11] = '{OP_JALR,  32'h40,  32'h1003,     32'h4,        32'h0,  32'h44,       1'b1, 1'b1, 32'h1006};
        vt[12] = '{OP_BNE,   32'h100, 32'h1,        32'h2,        32'h20, 32'h0,        1'b0, 1'b1, 32'h120};
        vt[13] = '{OP_BEQ,   32'h100, 32'h1,        32'h2,        32'h20, 32'h0,        1'b0, 1'b0, 32'h0};
        vt[14] = '{OP_BLT,   32'h100, 32'hffffffff, 32'h1,        32'h8,  32'h0,        1'b0, 1'b1, 32'h108};
        vt[15] = '{OP_BGE,   32'h100, 32'hffffffff, 32'h1,        32'h8,  32'h0,        1'b0, 1'b0, 32'h0};
        vt[16] = '{OP_BLTU,  32'h100, 32'hffffffff, 32'h1,        32'h8,  32'h0,        1'b0, 1'b0, 32'h0};
        vt[17] = '{OP_BGEU,  32'h100, 32'hffffffff, 32'h1,        32'h8,  32'h0,        1'b0, 1'b1, 32'h108};
        vt[18] = '{6'h3f,    32'h100, 32'h5,        32'h6,        32'h8,  32'h0,        1'b0, 1'b0, 32'h0};
        bus.res_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            drive_disp(vt[k].op, vt[k].pc, 4'd0, 4'd0, vt[k].x, vt[k].y, vt[k].imm, 4'(k % 15 + 1), 5'(k));
            tick();
            idle_inputs();
            tick();
            n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'(k % 15 + 1)) begin n_err++; $display("FAIL op%0d_valid: got v=%b tag=%0d want 1 %0d", k, bus.res_valid, bus.res_tag, k % 15 + 1); end
            n_cmp++; if (bus.res_data !== vt[k].d) begin n_err++; $display("FAIL op%0d_data: got %h want %h", k, bus.res_data, vt[k].d); end
            n_cmp++; if (bus.res_wen !== vt[k].wen) begin n_err++; $display("FAIL op%0d_wen: got %b want %b", k, bus.res_wen, vt[k].wen); end
            n_cmp++; if (bus.res_jmp_en !== vt[k].jen) begin n_err++; $display("FAIL op%0d_jmp_en: got %b want %b", k, bus.res_jmp_en, vt[k].jen); end
            n_cmp++; if (bus.res_jmp_addr !== vt[k].ja) begin n_err++; $display("FAIL op%0d_jmp_addr: got %h want %h", k, bus.res_jmp_addr, vt[k].ja); end
        end
        tick();
    endtask

    task automatic test_flush_rdy_reset;
        bus.res_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive_disp(OP_ADD, 32'h0, 4'd0, 4'd0, 32'(k), 32'd1, 32'd0, 4'(k), 5'(k));
            tick();
        end
        n_cmp++; if (bus.count !== 3'd3 || bus.res_valid !== 1'b1 || bus.res_tag !== 4'd1) begin n_err++; $display("FAIL fl_setup: got count=%0d v=%b tag=%0d want 3 1 1", bus.count, bus.res_valid, bus.res_tag); end
        rdy = 1'b0;
        drive_disp(OP_ADD, 32'h0, 4'd0, 4'd0, 32'd9, 32'd9, 32'd0, 4'd9, 5'd9);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd1; bus.cdb_data = 32'h55;
        bus.res_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL rdy0_count: got %0d want 3", bus.count); end
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd1 || bus.res_data !== 32'd2) begin n_err++; $display("FAIL rdy0_res: got v=%b tag=%0d data=%h want 1 1 2", bus.res_valid, bus.res_tag, bus.res_data); end
        rdy = 1'b1; flush = 1'b1; bus.res_ready = 1'b0; bus.cdb_valid = 1'b0;
        #1;
        n_cmp++; if (bus.disp_ready !== 1'b0) begin n_err++; $display("FAIL fl_disp_ready: got %b want 0", bus.disp_ready); end
        tick();
        n_cmp++; if (bus.count !== 3'd0 || bus.res_valid !== 1'b0) begin n_err++; $display("FAIL fl_clear: got count=%0d v=%b want 0 0", bus.count, bus.res_valid); end
        flush = 1'b0;
        idle_inputs();
        tick();
        n_cmp++; if (bus.count !== 3'd0 || bus.res_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin n_err++; $display("FAIL fl_dropped: got count=%0d v=%b drdy=%b want 0 0 1", bus.count, bus.res_valid, bus.disp_ready); end
        drive_disp(OP_ADD, 32'h0, 4'd0, 4'd0, 32'd5, 32'd5, 32'd0, 4'd2, 5'd2); tick();
        drive_disp(OP_ADD, 32'h0, 4'd0, 4'd0, 32'd6, 32'd6, 32'd0, 4'd3, 5'd3); tick();
        idle_inputs();
        n_cmp++; if (bus.count !== 3'd1 || bus.res_valid !== 1'b1 || bus.res_data !== 32'd10) begin n_err++; $display("FAIL rst_setup: got count=%0d v=%b data=%h want 1 1 a", bus.count, bus.res_valid, bus.res_data); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 3'd0 || bus.res_valid !== 1'b0 || bus.res_data !== 32'd0 || bus.res_tag !== 4'd0) begin n_err++; $display("FAIL rst_async: got count=%0d v=%b data=%h tag=%0d want 0 0 0 0", bus.count, bus.res_valid, bus.res_data, bus.res_tag); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.count !== 3'd0 || bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_after: got count=%0d v=%b want 0 0", bus.count, bus.res_valid); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_add();
        test_wakeup();
        test_bypass();
        test_back_to_back();
        test_alu_ops();
        test_flush_rdy_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
